// File: rtl/triang_row_seq.sv
// Row-fetch sequencer: credit-limited row prefetch, triangular masking and valid/ready row stream.
// Optional busy/stall performance counters are compiled in when TRI_SEQ_PERF_EN is defined.
module triang_row_seq #(
    parameter int unsigned MAX_SIZE   = 16,
    parameter int unsigned ELEM_W     = 128,
    parameter int unsigned FIFO_DEPTH = 4,
    localparam int unsigned AW    = $clog2(MAX_SIZE),
    localparam int unsigned NW    = $clog2(MAX_SIZE + 1),
    localparam int unsigned ROW_W = MAX_SIZE * ELEM_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [NW-1:0]    n_i,
    input  logic             upper_i,
    input  logic             flush_i,
    output logic [AW-1:0]    req_addr_o,
    output logic             req_valid_o,
    input  logic             req_ready_i,
    input  logic [ROW_W-1:0] rsp_row_i,
    input  logic [AW-1:0]    rsp_addr_i,
    input  logic             rsp_valid_i,
    output logic [ROW_W-1:0] row_o,
    output logic [AW-1:0]    row_addr_o,
    output logic             row_valid_o,
    input  logic             row_ready_i,
    output logic             row_last_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o
`ifdef TRI_SEQ_PERF_EN
    ,
    output logic [31:0]      cyc_cnt_o,
    output logic [31:0]      stall_cnt_o
`endif
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_DRAIN = 3'd2,
        S_DONE  = 3'd3,
        S_FLUSH = 3'd4
    } state_e;

    state_e            state_q, state_d;
    logic [NW-1:0]     n_q, n_d, req_cnt_q, req_cnt_d, out_cnt_q, out_cnt_d;
    logic              upper_q, upper_d, err_q, err_d, done_q, done_d;
    logic [AW-1:0]     req_addr_q, req_addr_d, rsp_exp_q, rsp_exp_d;
    logic [CW-1:0]     outst_q, outst_d, cnt_q, cnt_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [ROW_W-1:0]  fifo_mem [FIFO_DEPTH];
    logic [ROW_W-1:0]  masked_c;
    logic [NW-1:0]     n_clamp_c;
    logic              req_hs_c, push_c, pop_c, row_valid_c, clear_c;

    assign n_clamp_c   = (n_i > NW'(MAX_SIZE)) ? NW'(MAX_SIZE) : n_i;
    assign row_valid_c = (cnt_q != '0);
    assign req_valid_o = (state_q == S_RUN) &&
                         (((CW+1)'(outst_q) + (CW+1)'(cnt_q)) < (CW+1)'(FIFO_DEPTH));
    assign req_hs_c    = req_valid_o && req_ready_i;
    assign push_c      = rsp_valid_i && ((state_q == S_RUN) || (state_q == S_DRAIN));
    assign pop_c       = row_valid_c && row_ready_i;

    // Zero everything outside the triangle of the row being pushed (row index = expected address).
    always_comb begin
        masked_c = rsp_row_i;
        for (int unsigned j = 0; j < MAX_SIZE; j++) begin
            if (!((NW'(j) < n_q) && (upper_q ? (AW'(j) >= rsp_exp_q) : (AW'(j) <= rsp_exp_q)))) begin
                masked_c[j*ELEM_W +: ELEM_W] = '0;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        upper_d    = upper_q;
        err_d      = err_q;
        done_d     = 1'b0;
        clear_c    = 1'b0;
        req_cnt_d  = req_cnt_q;
        req_addr_d = req_addr_q;
        rsp_exp_d  = rsp_exp_q;
        out_cnt_d  = out_cnt_q;
        outst_d    = outst_q + CW'(req_hs_c) - CW'(rsp_valid_i);

        if (req_hs_c) begin
            req_cnt_d  = req_cnt_q + NW'(1);
            req_addr_d = upper_q ? req_addr_q - AW'(1) : req_addr_q + AW'(1);
        end
        if (push_c) begin
            rsp_exp_d = upper_q ? rsp_exp_q - AW'(1) : rsp_exp_q + AW'(1);
            if (rsp_addr_i != rsp_exp_q) err_d = 1'b1;
        end
        if (pop_c) out_cnt_d = out_cnt_q + NW'(1);

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    n_d        = n_clamp_c;
                    upper_d    = upper_i;
                    err_d      = 1'b0;
                    req_cnt_d  = '0;
                    out_cnt_d  = '0;
                    req_addr_d = upper_i ? AW'(n_clamp_c - NW'(1)) : '0;
                    rsp_exp_d  = upper_i ? AW'(n_clamp_c - NW'(1)) : '0;
                    state_d    = (n_clamp_c == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (flush_i) begin
                    state_d = S_FLUSH;
                    clear_c = 1'b1;
                end else if (req_hs_c && (req_cnt_q == n_q - NW'(1))) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (flush_i) begin
                    state_d = S_FLUSH;
                    clear_c = 1'b1;
                end else if ((out_cnt_q == n_q) && (outst_q == '0) && (cnt_q == '0)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done_d  = !flush_i;
                state_d = flush_i ? S_FLUSH : S_IDLE;
                clear_c = flush_i;
            end
            S_FLUSH: begin
                if (outst_d == '0) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        cnt_d    = clear_c ? '0 : cnt_q + CW'(push_c) - CW'(pop_c);
        wr_ptr_d = clear_c ? '0 : (push_c ? wr_ptr_q + PW'(1) : wr_ptr_q);
        rd_ptr_d = clear_c ? '0 : (pop_c ? rd_ptr_q + PW'(1) : rd_ptr_q);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            n_q        <= '0;
            upper_q    <= 1'b0;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
            req_cnt_q  <= '0;
            req_addr_q <= '0;
            rsp_exp_q  <= '0;
            out_cnt_q  <= '0;
            outst_q    <= '0;
            cnt_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            upper_q    <= upper_d;
            err_q      <= err_d;
            done_q     <= done_d;
            req_cnt_q  <= req_cnt_d;
            req_addr_q <= req_addr_d;
            rsp_exp_q  <= rsp_exp_d;
            out_cnt_q  <= out_cnt_d;
            outst_q    <= outst_d;
            cnt_q      <= cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    // Row storage carries no reset; unread slots are gated off at the output.
    always_ff @(posedge clk_i) begin
        if (push_c) fifo_mem[wr_ptr_q] <= masked_c;
    end

    assign req_addr_o  = req_addr_q;
    assign row_valid_o = row_valid_c;
    assign row_o       = row_valid_c ? fifo_mem[rd_ptr_q] : '0;
    assign row_addr_o  = row_valid_c ? (upper_q ? AW'(n_q - NW'(1) - out_cnt_q) : AW'(out_cnt_q)) : '0;
    assign row_last_o  = row_valid_c && (out_cnt_q == n_q - NW'(1));
    assign busy_o      = (state_q != S_IDLE);
    assign done_o      = done_q;
    assign err_o       = err_q;

`ifdef TRI_SEQ_PERF_EN
    logic [31:0] cyc_cnt_q, cyc_cnt_d, stall_cnt_q, stall_cnt_d;

    always_comb begin
        cyc_cnt_d   = cyc_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if ((state_q == S_IDLE) && start_i) begin
            cyc_cnt_d   = '0;
            stall_cnt_d = '0;
        end else begin
            if (state_q != S_IDLE) cyc_cnt_d = cyc_cnt_q + 32'd1;
            if (row_valid_c && !row_ready_i) stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cyc_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            cyc_cnt_q   <= cyc_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign cyc_cnt_o   = cyc_cnt_q;
    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_triang_row_seq.sv
// Bench for triang_row_seq: latency-modelled memory, list-based row/request model, vector table plus corner sequences.
module tb_triang_row_seq;

    localparam int unsigned MAX_SIZE = 16;
    localparam int unsigned ELEM_W   = 128;
    localparam int unsigned AW       = 4;
    localparam int unsigned NW       = 5;
    localparam int unsigned ROW_W    = MAX_SIZE * ELEM_W;

    logic             clk_i = 1'b0;
    logic             rst_i, start_i, upper_i, flush_i;
    logic [NW-1:0]    n_i;
    logic [AW-1:0]    req_addr_o, rsp_addr_i, row_addr_o;
    logic             req_valid_o, req_ready_i, rsp_valid_i;
    logic [ROW_W-1:0] rsp_row_i, row_o;
    logic             row_valid_o, row_ready_i, row_last_o, busy_o, done_o, err_o;

    triang_row_seq dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .n_i(n_i), .upper_i(upper_i),
        .flush_i(flush_i), .req_addr_o(req_addr_o), .req_valid_o(req_valid_o),
        .req_ready_i(req_ready_i), .rsp_row_i(rsp_row_i), .rsp_addr_i(rsp_addr_i),
        .rsp_valid_i(rsp_valid_i), .row_o(row_o), .row_addr_o(row_addr_o),
        .row_valid_o(row_valid_o), .row_ready_i(row_ready_i), .row_last_o(row_last_o),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct { int n_in; bit up; int lat; int rq_pct; int rr_pct; int exp_rows; } pass_t;
    typedef struct { logic [AW-1:0] addr; int due; } memreq_t;
    typedef struct { logic [AW-1:0] addr; logic [ROW_W-1:0] row; bit last; } exprow_t;

    int checks = 0, errors = 0, cyc = 0;
    int lat_v = 2, rq_pct = 100, rr_pct = 100, corrupt_idx = -1, rsp_idx = 0;
    int done_cnt, busy_cyc, hs_cnt, rsp_cnt, pop_cnt, reqv_cnt, rv_cnt, last_rsp_cyc;
    bit st_v = 1'b0, fl_v = 1'b0;
    bit prev_req_stall = 1'b0, prev_row_stall = 1'b0;
    logic [AW-1:0]    prev_req_addr, prev_row_addr;
    logic [ROW_W-1:0] prev_row;
    memreq_t memq[$];
    logic [AW-1:0] exp_req[$];
    exprow_t exp_rows[$];
    logic [ELEM_W-1:0] mem_rows [MAX_SIZE][MAX_SIZE];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_row(input string name, input logic [ROW_W-1:0] act, input logic [ROW_W-1:0] exp);
        int bad;
        checks++;
        if (act !== exp) begin
            errors++;
            bad = 0;
            for (int j = MAX_SIZE - 1; j >= 0; j--)
                if (act[j*ELEM_W +: ELEM_W] !== exp[j*ELEM_W +: ELEM_W]) bad = j;
            $display("FAIL %s elem %0d got %0h expected %0h (cycle %0d)", name, bad,
                     act[bad*ELEM_W +: 64], exp[bad*ELEM_W +: 64], cyc);
        end
    endtask

    // One clock cycle: drive inputs at the falling edge, then observe what the next rising edge will take.
    task automatic step();
        memreq_t m;
        exprow_t e;
        logic [ROW_W-1:0] r;
        @(negedge clk_i);
        start_i     = st_v;
        flush_i     = fl_v;
        req_ready_i = (int'($urandom_range(99)) < rq_pct);
        row_ready_i = (int'($urandom_range(99)) < rr_pct);
        if (memq.size() > 0 && memq[0].due <= cyc) begin
            m = memq.pop_front();
            for (int j = 0; j < int'(MAX_SIZE); j++) r[j*ELEM_W +: ELEM_W] = mem_rows[m.addr][j];
            rsp_valid_i  = 1'b1;
            rsp_addr_i   = (rsp_idx == corrupt_idx) ? m.addr + AW'(1) : m.addr;
            rsp_row_i    = r;
            rsp_idx++;
            rsp_cnt++;
            last_rsp_cyc = cyc;
        end else begin
            rsp_valid_i = 1'b0;
            rsp_addr_i  = '0;
            rsp_row_i   = '0;
        end

        if (req_valid_o) reqv_cnt++;
        if (prev_req_stall && req_valid_o) check("req_addr_stable", 64'(req_addr_o), 64'(prev_req_addr));
        if (req_valid_o && req_ready_i) begin
            hs_cnt++;
            if (exp_req.size() == 0) begin
                checks++; errors++;
                $display("FAIL req_extra addr %0d (cycle %0d)", req_addr_o, cyc);
            end else begin
                check("req_addr", 64'(req_addr_o), 64'(exp_req.pop_front()));
            end
            m.addr = req_addr_o;
            m.due  = cyc + lat_v;
            memq.push_back(m);
        end
        prev_req_stall = req_valid_o && !req_ready_i;
        prev_req_addr  = req_addr_o;

        if (row_valid_o) rv_cnt++;
        if (prev_row_stall) begin
            check("row_valid_hold", 64'(row_valid_o), 64'(1));
            check("row_addr_stable", 64'(row_addr_o), 64'(prev_row_addr));
            check_row("row_stable", row_o, prev_row);
        end
        if (row_valid_o && row_ready_i) begin
            pop_cnt++;
            if (exp_rows.size() == 0) begin
                checks++; errors++;
                $display("FAIL row_extra addr %0d (cycle %0d)", row_addr_o, cyc);
            end else begin
                e = exp_rows.pop_front();
                check("row_addr", 64'(row_addr_o), 64'(e.addr));
                check("row_last", 64'(row_last_o), 64'(e.last));
                check_row("row_data", row_o, e.row);
            end
        end
        prev_row_stall = row_valid_o && !row_ready_i;
        prev_row       = row_o;
        prev_row_addr  = row_addr_o;

        if (done_o) done_cnt++;
        if (busy_o) busy_cyc++;
        cyc++;
    endtask

    // Reference: rows in pass order, element kept iff inside the triangle and below n.
    task automatic prepare(input int n_in, input bit up, input int corrupt);
        int ne;
        exprow_t e;
        ne = (n_in > int'(MAX_SIZE)) ? int'(MAX_SIZE) : n_in;
        for (int a = 0; a < int'(MAX_SIZE); a++)
            for (int j = 0; j < int'(MAX_SIZE); j++)
                mem_rows[a][j] = {$urandom, $urandom, $urandom, $urandom | 32'h1};
        exp_req.delete();
        exp_rows.delete();
        for (int k = 0; k < ne; k++) begin
            int rr;
            rr = up ? ne - 1 - k : k;
            exp_req.push_back(AW'(rr));
            e.addr = AW'(rr);
            e.last = (k == ne - 1);
            for (int j = 0; j < int'(MAX_SIZE); j++)
                e.row[j*ELEM_W +: ELEM_W] = (j < ne && (up ? j >= rr : j <= rr)) ? mem_rows[rr][j] : '0;
            exp_rows.push_back(e);
        end
        corrupt_idx = corrupt;
        rsp_idx = 0; done_cnt = 0; busy_cyc = 0; hs_cnt = 0; rsp_cnt = 0;
        pop_cnt = 0; reqv_cnt = 0; rv_cnt = 0; last_rsp_cyc = 0;
        n_i     = NW'(n_in);
        upper_i = up;
    endtask

    task automatic start_pass();
        st_v = 1'b1;
        step();
        st_v = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int t;
        t = 0;
        while (done_cnt == 0 && t < budget) begin
            step();
            t++;
        end
        if (done_cnt == 0) begin
            checks++; errors++;
            $display("FAIL done_timeout no done_o within %0d cycles", budget);
        end
        repeat (3) step();
    endtask

    task automatic finish_pass(input int ne, input bit err_exp);
        check("done_pulses", 64'(done_cnt), 64'(1));
        check("reqs_left", 64'(exp_req.size()), 64'(0));
        check("rows_left", 64'(exp_rows.size()), 64'(0));
        check("rows_out", 64'(pop_cnt), 64'(ne));
        check("err", 64'(err_o), 64'(err_exp));
        check("busy_end", 64'(busy_o), 64'(0));
    endtask

    pass_t tbl[10];

    initial begin
        int t, nr;
        tbl[0] = '{4,  1'b0, 2, 100, 100, 4};
        tbl[1] = '{5,  1'b1, 2, 100, 100, 5};
        tbl[2] = '{16, 1'b0, 1, 100, 100, 16};
        tbl[3] = '{16, 1'b1, 3, 70,  60,  16};
        tbl[4] = '{20, 1'b0, 2, 80,  50,  16};
        tbl[5] = '{1,  1'b0, 1, 100, 100, 1};
        tbl[6] = '{1,  1'b1, 4, 50,  50,  1};
        tbl[7] = '{7,  1'b1, 1, 100, 30,  7};
        tbl[8] = '{9,  1'b0, 5, 60,  90,  9};
        tbl[9] = '{31, 1'b1, 2, 90,  80,  16};

        rst_i = 1'b1; start_i = 1'b0; n_i = '0; upper_i = 1'b0; flush_i = 1'b0;
        req_ready_i = 1'b0; rsp_valid_i = 1'b0; rsp_addr_i = '0; rsp_row_i = '0; row_ready_i = 1'b0;
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        check("rst_req_valid", 64'(req_valid_o), 64'(0));
        check("rst_req_addr", 64'(req_addr_o), 64'(0));
        check("rst_row_valid", 64'(row_valid_o), 64'(0));
        check("rst_row_last", 64'(row_last_o), 64'(0));
        check("rst_row_addr", 64'(row_addr_o), 64'(0));
        check_row("rst_row", row_o, '0);
        check("rst_busy", 64'(busy_o), 64'(0));
        check("rst_done", 64'(done_o), 64'(0));
        check("rst_err", 64'(err_o), 64'(0));

        for (int i = 0; i < 10; i++) begin
            prepare(tbl[i].n_in, tbl[i].up, -1);
            lat_v = tbl[i].lat; rq_pct = tbl[i].rq_pct; rr_pct = tbl[i].rr_pct;
            start_pass();
            wait_done(3000);
            finish_pass(tbl[i].exp_rows, 1'b0);
        end

        // n == 0: straight to DONE, one busy cycle, done two cycles after start.
        prepare(0, 1'b0, -1);
        rq_pct = 100; rr_pct = 100;
        start_pass();
        step();
        check("n0_busy", 64'(busy_o), 64'(1));
        check("n0_done_early", 64'(done_o), 64'(0));
        step();
        check("n0_done", 64'(done_o), 64'(1));
        check("n0_busy_after", 64'(busy_o), 64'(0));
        step();
        check("n0_done_once", 64'(done_o), 64'(0));
        check("n0_reqs", 64'(reqv_cnt), 64'(0));
        check("n0_busy_cycles", 64'(busy_cyc), 64'(1));

        // Downstream stalled: credits cap fetches at FIFO_DEPTH, then release.
        prepare(8, 1'b0, -1);
        lat_v = 1; rq_pct = 100; rr_pct = 0;
        start_pass();
        repeat (30) step();
        check("stall_reqs", 64'(hs_cnt), 64'(4));
        check("stall_req_valid", 64'(req_valid_o), 64'(0));
        check("stall_row_valid", 64'(row_valid_o), 64'(1));
        rr_pct = 100;
        wait_done(3000);
        finish_pass(8, 1'b0);

        // Flush with three requests outstanding.
        prepare(8, 1'b0, -1);
        lat_v = 6; rq_pct = 100; rr_pct = 100;
        start_pass();
        t = 0;
        while (hs_cnt < 3 && t < 50) begin step(); t++; end
        check("flush_pre_hs", 64'(hs_cnt), 64'(3));
        rq_pct = 0; fl_v = 1'b1;
        step();
        fl_v = 1'b0;
        reqv_cnt = 0;
        t = 0;
        while (busy_o && t < 60) begin step(); t++; end
        check("flush_idle", 64'(busy_o), 64'(0));
        check("flush_rsps", 64'(rsp_cnt), 64'(3));
        check("flush_idle_lat", 64'(cyc - 1 - last_rsp_cyc), 64'(1));
        check("flush_no_req", 64'(reqv_cnt), 64'(0));
        check("flush_no_row", 64'(rv_cnt), 64'(0));
        check("flush_no_done", 64'(done_cnt), 64'(0));
        check("flush_memq", 64'(memq.size()), 64'(0));
        repeat (3) step();
        check("flush_done_after", 64'(done_cnt), 64'(0));

        // Wrong response address: sticky error until the next accepted start.
        prepare(3, 1'b0, 1);
        lat_v = 2; rq_pct = 100; rr_pct = 100;
        start_pass();
        wait_done(3000);
        finish_pass(3, 1'b1);
        repeat (5) step();
        check("err_sticky", 64'(err_o), 64'(1));
        prepare(4, 1'b1, -1);
        check("err_before_start", 64'(err_o), 64'(1));
        start_pass();
        step();
        check("err_cleared", 64'(err_o), 64'(0));
        wait_done(3000);
        finish_pass(4, 1'b0);

        // Randomized passes.
        for (int i = 0; i < 8; i++) begin
            nr = int'($urandom_range(20));
            prepare(nr, 1'($urandom_range(1)), -1);
            lat_v  = int'($urandom_range(6, 1));
            rq_pct = int'($urandom_range(100, 30));
            rr_pct = int'($urandom_range(100, 30));
            start_pass();
            wait_done(3000);
            finish_pass((nr > 16) ? 16 : nr, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
